// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over a req/ready handshake and loads IF/ID.
// A one-entry skid buffer keeps a fetch landing during a stall; DROP swallows a fetch orphaned by a redirect.
//   state   | meaning
//   S_FETCH | request at pc outstanding, completed fetch goes to IF/ID (or buffer if stalled)
//   S_BUF   | skid buffer holds a fetched instruction waiting for the stall to clear
//   S_DROP  | request at drop_addr still outstanding after a redirect; its data is discarded
module fetch_unit #(
  parameter int unsigned       PC_W     = 64,
  parameter int unsigned       INSN_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Stall,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INSN_W-1:0] ifid_insn,
  output logic              ifid_valid,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_BUF   = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     drop_q, drop_d;
  logic [PC_W-1:0]     bpc_q, bpc_d;
  logic [INSN_W-1:0]   binsn_q, binsn_d;
  logic [PC_W-1:0]     ifid_pc_d;
  logic [INSN_W-1:0]   ifid_insn_d;
  logic                ifid_valid_d;
  logic [PC_W-1:0]     br_pc;
  logic [PC_W-1:0]     pc_inc;
  logic                unused_br_lsb;

  // Redirect targets are forced word aligned, so the low bits never matter.
  assign br_pc         = {br_target[PC_W-1:2], 2'b00};
  assign unused_br_lsb = ^br_target[1:0];
  assign pc_inc        = pc_q + {{(PC_W-3){1'b0}}, 3'd4};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    bpc_d        = bpc_q;
    binsn_d      = binsn_q;
    ifid_pc_d    = ifid_pc;
    ifid_insn_d  = ifid_insn;
    ifid_valid_d = ifid_valid;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    case (state_q)
      S_FETCH: imem_req = !reset;
      S_DROP: begin
        imem_req  = !reset;
        imem_addr = drop_q;
      end
      default: ;
    endcase

    if (br_taken) begin
      ifid_valid_d = 1'b0;
      pc_d         = br_pc;
      case (state_q)
        S_FETCH: begin
          // The in-flight request cannot be withdrawn, so park its address and eat the response.
          if (!imem_ready) begin
            drop_d  = pc_q;
            state_d = S_DROP;
          end
        end
        S_BUF:   state_d = S_FETCH;
        S_DROP:  if (imem_ready) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_inc;
            if (Stall) begin
              bpc_d   = pc_q;
              binsn_d = imem_rdata;
              state_d = S_BUF;
            end else begin
              ifid_pc_d    = pc_q;
              ifid_insn_d  = imem_rdata;
              ifid_valid_d = 1'b1;
            end
          end else if (!Stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        S_BUF: begin
          if (!Stall) begin
            ifid_pc_d    = bpc_q;
            ifid_insn_d  = binsn_q;
            ifid_valid_d = 1'b1;
            state_d      = S_FETCH;
          end
        end
        S_DROP:  if (imem_ready) state_d = S_FETCH;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drop_q       <= '0;
      bpc_q        <= '0;
      binsn_q      <= '0;
      ifid_pc      <= '0;
      ifid_insn    <= '0;
      ifid_valid   <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      bpc_q      <= bpc_d;
      binsn_q    <= binsn_d;
      ifid_pc    <= ifid_pc_d;
      ifid_insn  <= ifid_insn_d;
      ifid_valid <= ifid_valid_d;
      if (Stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random stall/redirect/ready traffic,
// checked against an in-order instruction-stream scoreboard and handshake rules.
module tb_fetch_unit;
  localparam int          PC_W   = 64;
  localparam int          INSN_W = 32;
  localparam logic [63:0] RST_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int          N_RAND = 4000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              Stall = 1'b0;
  logic              br_taken = 1'b0;
  logic [PC_W-1:0]   br_target = '0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ready = 1'b0;
  logic [INSN_W-1:0] imem_rdata;
  logic [PC_W-1:0]   ifid_pc;
  logic [INSN_W-1:0] ifid_insn;
  logic              ifid_valid;
  logic [31:0]       stall_cycles;

  fetch_unit #(.PC_W(PC_W), .INSN_W(INSN_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .Stall(Stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ifid_pc(ifid_pc), .ifid_insn(ifid_insn), .ifid_valid(ifid_valid), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Instruction memory: content is a fixed scramble of the address, answered combinationally.
  function automatic logic [31:0] insn_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction
  assign imem_rdata = insn_of(imem_addr);

  int checks = 0;
  int passes = 0;
  int deliveries = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected program-order stream of PCs that IF/ID must present.
  logic [63:0] exp_q[$];
  logic [63:0] last_pushed;

  task automatic topup();
    while (exp_q.size() < 8) begin
      last_pushed = last_pushed + 64'd4;
      exp_q.push_back(last_pushed);
    end
  endtask

  task automatic restart(input logic [63:0] start);
    exp_q.delete();
    exp_q.push_back(start);
    last_pushed = start;
    topup();
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [63:0] t, input logic rdy);
    @(negedge clk);
    #1;
    reset      = r;
    Stall      = s;
    br_taken   = b;
    br_target  = t;
    imem_ready = rdy;
    if (r)      restart(RST_PC);
    else if (b) restart({t[63:2], 2'b00});
    else        topup();
  endtask

  // Monitor: compare results of the edge just passed, then capture the context of the next edge.
  logic        c_reset, c_stall, c_br, c_req, c_ready, c_ok;
  logic [63:0] c_addr;
  logic [63:0] p_pc;
  logic [31:0] p_insn;
  logic        p_valid;
  logic [31:0] m_stall;
  logic        discard;

  initial begin
    logic        was_discard;
    logic        exp_v;
    logic [63:0] e_pc;
    c_ok = 1'b0; m_stall = '0; discard = 1'b0;
    p_pc = '0; p_insn = '0; p_valid = 1'b0;
    @(negedge clk);
    forever begin
      if (c_ok) begin
        if (c_reset) begin
          check("reset_valid", {63'd0, ifid_valid}, 64'd0);
          check("reset_pc", ifid_pc, 64'd0);
          check("reset_insn", {32'd0, ifid_insn}, 64'd0);
          check("reset_stall_cycles", {32'd0, stall_cycles}, 64'd0);
          m_stall = '0;
          discard = 1'b0;
        end else begin
          if (c_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
          check("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
          was_discard = discard;
          if (c_br) begin
            check("redirect_bubble", {63'd0, ifid_valid}, 64'd0);
            discard = c_req && !c_ready;
          end else begin
            if (c_req && c_ready && was_discard) discard = 1'b0;
            if (c_stall) begin
              check("stall_hold_pc", ifid_pc, p_pc);
              check("stall_hold_insn", {32'd0, ifid_insn}, {32'd0, p_insn});
              check("stall_hold_valid", {63'd0, ifid_valid}, {63'd0, p_valid});
            end else begin
              exp_v = !c_req || (c_ready && !was_discard);
              check("ifid_valid", {63'd0, ifid_valid}, {63'd0, exp_v});
              if (ifid_valid) begin
                if (exp_q.size() == 0) begin
                  check("stream_underflow", 64'd1, 64'd0);
                end else begin
                  e_pc = exp_q.pop_front();
                  check("ifid_pc", ifid_pc, e_pc);
                  check("ifid_insn", {32'd0, ifid_insn}, {32'd0, insn_of(e_pc)});
                  deliveries++;
                end
              end
            end
          end
        end
      end
      p_pc = ifid_pc; p_insn = ifid_insn; p_valid = ifid_valid;
      #2;
      if (reset) check("req_low_in_reset", {63'd0, imem_req}, 64'd0);
      else if (c_ok && !c_reset && c_req && !c_ready) begin
        check("req_held", {63'd0, imem_req}, 64'd1);
        check("addr_held", imem_addr, c_addr);
      end
      c_reset = reset; c_stall = Stall; c_br = br_taken;
      c_req = imem_req; c_ready = imem_ready; c_addr = imem_addr;
      c_ok = 1'b1;
      @(negedge clk);
    end
  end

  initial begin
    logic        r, s, b, rdy;
    logic [63:0] t;
    restart(RST_PC);
    repeat (3) drive(1, 0, 0, '0, 0);
    // Straight-line fetch from RESET_PC through the wrap to 0.
    repeat (6) drive(0, 0, 0, '0, 1);
    // Stall with memory ready: skid buffer then release.
    repeat (3) drive(0, 1, 0, '0, 1);
    repeat (3) drive(0, 0, 0, '0, 1);
    // Memory not ready.
    repeat (2) drive(0, 0, 0, '0, 0);
    repeat (2) drive(0, 0, 0, '0, 1);
    // Redirect while a request is pending, unaligned target.
    drive(0, 0, 1, 64'h103, 0);
    drive(0, 0, 0, '0, 0);
    repeat (4) drive(0, 0, 0, '0, 1);
    // Redirect and stall together while the buffer is full.
    drive(0, 1, 0, '0, 1);
    drive(0, 1, 1, 64'h203, 1);
    repeat (4) drive(0, 0, 0, '0, 1);
    // Reset while dropping, then the two fetches across the wrap.
    drive(0, 0, 1, 64'h400, 0);
    drive(1, 0, 0, '0, 0);
    repeat (4) drive(0, 0, 0, '0, 1);
    for (int i = 0; i < N_RAND; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 15) == 0);
      t   = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31)))
                                        : {$urandom, $urandom};
      rdy = ($urandom_range(0, 9) < 6);
      drive(r, s, b, t, rdy);
    end
    repeat (5) drive(0, 0, 0, '0, 1);
    @(negedge clk);
    #3;
    check("forward_progress", {63'd0, deliveries >= 500}, 64'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
